mem_sequencer: RTL and testbench

Multi-cycle sequencer that sits directly upstream of the byte-addressed memory block (MAR/MDR + 256x8 RAM). It converts single-transaction 16-bit read and write requests into the cycle-by-cycle control pulses and bus values that memory needs: `mar_load`, `mdr_load_bus`, `mdr_load_low`, `mdr_load_high` and `ram_write`. It returns read data, and write acknowledgement, on a one-cycle response pulse. Words are little-endian: the low byte is at `addr`, the high byte at `addr+1`.

---
 rtl/mem_sequencer_if.sv | 40 ++++
 rtl/mem_sequencer.sv | 141 ++++++++++++++
 tb/tb_mem_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sequencer_if.sv
// Request/response handshake and memory control bundle for mem_sequencer.
// With MEMSEQ_BYTE_READ_EN defined the bundle also carries req_byte.
interface mem_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
`ifdef MEMSEQ_BYTE_READ_EN
  logic        req_byte;
`endif
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [15:0] mdr_in;
  logic        mar_load;
  logic        mdr_load_bus;
  logic        mdr_load_low;
  logic        mdr_load_high;
  logic        ram_write;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mdr_in,
`ifdef MEMSEQ_BYTE_READ_EN
    input  req_byte,
`endif
    output req_ready, resp_valid, resp_data, bus_out, bus_oe,
    output mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mdr_in,
`ifdef MEMSEQ_BYTE_READ_EN
    output req_byte,
`endif
    input  req_ready, resp_valid, resp_data, bus_out, bus_oe,
    input  mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write
  );
endinterface

// File: rtl/mem_sequencer.sv
// Turns 16-bit read/write requests into MAR/MDR/RAM control pulses; response 3 cycles after accept.
// MEMSEQ_BYTE_READ_EN adds req_byte: byte reads skip the high-byte cycle (2-cycle latency).
module mem_sequencer (
  input  logic           clk,
  input  logic           rst,
  mem_sequencer_if.slave sq
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR0, WR1, WR2, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic        byte_q, byte_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] bus_out_q, bus_out_d;
  logic        bus_oe_q, bus_oe_d;
  logic        mar_load_q, mar_load_d;
  logic        mdr_load_bus_q, mdr_load_bus_d;
  logic        mdr_load_low_q, mdr_load_low_d;
  logic        mdr_load_high_q, mdr_load_high_d;
  logic        ram_write_q, ram_write_d;

  logic        accept;
  assign accept = sq.req_valid && req_ready_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    byte_d  = byte_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = sq.req_addr;
          d_d     = sq.req_wdata;
`ifdef MEMSEQ_BYTE_READ_EN
          byte_d  = sq.req_byte && !sq.req_write;
`else
          byte_d  = 1'b0;
`endif
          state_d = sq.req_write ? WR0 : RD0;
        end
      end
      RD0:     state_d = RD1;
      RD1:     state_d = byte_q ? DONE : RD2;
      RD2:     state_d = DONE;
      WR0:     state_d = WR1;
      WR1:     state_d = WR2;
      WR2:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state register.
  always_comb begin
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    bus_out_d       = 16'h0000;
    bus_oe_d        = 1'b0;
    mar_load_d      = 1'b0;
    mdr_load_bus_d  = 1'b0;
    mdr_load_low_d  = 1'b0;
    mdr_load_high_d = 1'b0;
    ram_write_d     = 1'b0;
    case (state_d)
      IDLE: req_ready_d = 1'b1;
      RD0, WR0: begin
        bus_oe_d   = 1'b1;
        bus_out_d  = a_d;
        mar_load_d = 1'b1;
      end
      RD1: begin
        mdr_load_low_d = 1'b1;
        if (!byte_d) begin
          bus_oe_d   = 1'b1;
          bus_out_d  = a_d + 16'd1;
          mar_load_d = 1'b1;
        end
      end
      RD2: mdr_load_high_d = 1'b1;
      WR1: begin
        bus_oe_d       = 1'b1;
        bus_out_d      = d_d;
        mdr_load_bus_d = 1'b1;
      end
      WR2:     ram_write_d  = 1'b1;
      DONE:    resp_valid_d = 1'b1;
      default: req_ready_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      a_q             <= 16'h0000;
      d_q             <= 16'h0000;
      byte_q          <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      bus_out_q       <= 16'h0000;
      bus_oe_q        <= 1'b0;
      mar_load_q      <= 1'b0;
      mdr_load_bus_q  <= 1'b0;
      mdr_load_low_q  <= 1'b0;
      mdr_load_high_q <= 1'b0;
      ram_write_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      d_q             <= d_d;
      byte_q          <= byte_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      bus_out_q       <= bus_out_d;
      bus_oe_q        <= bus_oe_d;
      mar_load_q      <= mar_load_d;
      mdr_load_bus_q  <= mdr_load_bus_d;
      mdr_load_low_q  <= mdr_load_low_d;
      mdr_load_high_q <= mdr_load_high_d;
      ram_write_q     <= ram_write_d;
    end
  end

  assign sq.req_ready     = req_ready_q;
  assign sq.resp_valid    = resp_valid_q;
  // Read data is live MDR contents, so it can only be gated here, not registered.
  assign sq.resp_data     = !resp_valid_q ? 16'h0000 :
                            byte_q        ? {8'h00, sq.mdr_in[7:0]} : sq.mdr_in;
  assign sq.bus_out       = bus_out_q;
  assign sq.bus_oe        = bus_oe_q;
  assign sq.mar_load      = mar_load_q;
  assign sq.mdr_load_bus  = mdr_load_bus_q;
  assign sq.mdr_load_low  = mdr_load_low_q;
  assign sq.mdr_load_high = mdr_load_high_q;
  assign sq.ram_write     = ram_write_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer driving a behavioural MAR/MDR/256x8 RAM model.
module tb_mem_sequencer;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mem_sequencer_if bus ();

  mem_sequencer dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  ram_m [256];
  logic [15:0] mar_m;
  logic [15:0] mdr_m;

  assign bus.mdr_in = mdr_m;

  always @(posedge clk) begin
    if (bus.mar_load)      mar_m <= bus.bus_out;
    if (bus.mdr_load_bus)  mdr_m <= bus.bus_out;
    if (bus.mdr_load_low)  mdr_m[7:0]  <= ram_m[mar_m[7:0]];
    if (bus.mdr_load_high) mdr_m[15:8] <= ram_m[mar_m[7:0]];
    if (bus.ram_write) begin
      ram_m[mar_m[7:0]]        <= mdr_m[7:0];
      ram_m[mar_m[7:0] + 8'd1] <= mdr_m[15:8];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fixed-cadence transaction: each phase is checked at the negedge of its cycle.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data, input logic [15:0] exp_mar1, input string tag);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    chk({tag, ".ready"}, 16'(bus.req_ready), 16'h1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, ".p0_mar"}, 16'(bus.mar_load), 16'h1);
    chk({tag, ".p0_bus"}, bus.bus_out, addr);
    chk({tag, ".p0_oe"}, 16'(bus.bus_oe), 16'h1);
    chk({tag, ".p0_busy"}, 16'(bus.req_ready), 16'h0);
    @(negedge clk);
    if (wr) begin
      chk({tag, ".p1_mdrbus"}, 16'(bus.mdr_load_bus), 16'h1);
      chk({tag, ".p1_bus"}, bus.bus_out, wdata);
    end else begin
      chk({tag, ".p1_mar"}, 16'(bus.mar_load), 16'h1);
      chk({tag, ".p1_low"}, 16'(bus.mdr_load_low), 16'h1);
      chk({tag, ".p1_bus"}, bus.bus_out, exp_mar1);
    end
    @(negedge clk);
    if (wr) chk({tag, ".p2_wr"}, 16'(bus.ram_write), 16'h1);
    else    chk({tag, ".p2_high"}, 16'(bus.mdr_load_high), 16'h1);
    chk({tag, ".p2_novld"}, 16'(bus.resp_valid), 16'h0);
    @(negedge clk);
    chk({tag, ".resp_vld"}, 16'(bus.resp_valid), 16'h1);
    chk({tag, ".resp_data"}, bus.resp_data, exp_data);
    @(negedge clk);
    chk({tag, ".after_vld"}, 16'(bus.resp_valid), 16'h0);
    chk({tag, ".after_rdy"}, 16'(bus.req_ready), 16'h1);
    chk({tag, ".after_data"}, bus.resp_data, 16'h0000);
  endtask

  initial begin
    int acc_cyc [2];
    int nacc;
    int nresp;
    int nlow;
    logic [15:0] resp_seen [2];
    logic rw_seen;
    logic rv_seen;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 16'h0000;
`ifdef MEMSEQ_BYTE_READ_EN
    bus.req_byte  = 1'b0;
`endif
    mar_m = 16'h0000;
    mdr_m = 16'h0000;
    for (int i = 0; i < 256; i++) ram_m[i] = 8'h00;
    ram_m[8'h10] = 8'h34;
    ram_m[8'h11] = 8'h12;
    ram_m[8'h30] = 8'h55;
    ram_m[8'h31] = 8'h66;
    ram_m[8'hFF] = 8'h78;
    ram_m[8'h00] = 8'h56;

    #2;
    chk("rst.ready", 16'(bus.req_ready), 16'h1);
    chk("rst.resp_vld", 16'(bus.resp_valid), 16'h0);
    chk("rst.resp_data", bus.resp_data, 16'h0000);
    chk("rst.bus_out", bus.bus_out, 16'h0000);
    chk("rst.oe", 16'(bus.bus_oe), 16'h0);
    chk("rst.ctrl", {11'd0, bus.mar_load, bus.mdr_load_bus, bus.mdr_load_low,
                     bus.mdr_load_high, bus.ram_write}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b0, 16'h0010, 16'h0000, 16'h1234, 16'h0011, "rd10");
    run_txn(1'b1, 16'h0020, 16'hBEEF, 16'hBEEF, 16'h0000, "wr20");
    chk("wr20.ram20", 16'(ram_m[8'h20]), 16'h00EF);
    chk("wr20.ram21", 16'(ram_m[8'h21]), 16'h00BE);
    run_txn(1'b0, 16'h0020, 16'h0000, 16'hBEEF, 16'h0021, "rd20");

    // Back-to-back reads with req_valid held high throughout.
    nacc  = 0;
    nresp = 0;
    nlow  = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0010;
    for (int c = 0; c < 30 && nresp < 2; c++) begin
      if (bus.resp_valid && nresp < 2) begin
        resp_seen[nresp] = bus.resp_data;
        nresp++;
      end
      if (bus.req_ready && bus.req_valid && nacc < 2) begin
        acc_cyc[nacc] = c;
        nacc++;
      end else if (nacc == 1) begin
        nlow++;
      end
      @(posedge clk);
      #1;
      if (nacc == 1) bus.req_addr = 16'h0020;
      if (nacc == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b.accepts", 16'(nacc), 16'd2);
    chk("b2b.resps", 16'(nresp), 16'd2);
    if (nacc == 2) chk("b2b.interval", 16'(acc_cyc[1] - acc_cyc[0]), 16'd5);
    chk("b2b.busy_cycles", 16'(nlow), 16'd4);
    if (nresp == 2) begin
      chk("b2b.resp0", resp_seen[0], 16'h1234);
      chk("b2b.resp1", resp_seen[1], 16'hBEEF);
    end
    repeat (3) @(negedge clk);

    // Reset during WR1 of a write of 0xAAAA to 0x30.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0030;
    bus.req_wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort.in_wr1", 16'(bus.mdr_load_bus), 16'h1);
    rst = 1'b1;
    #1;
    chk("abort.ready", 16'(bus.req_ready), 16'h1);
    chk("abort.oe", 16'(bus.bus_oe), 16'h0);
    chk("abort.bus_out", bus.bus_out, 16'h0000);
    chk("abort.ctrl", {11'd0, bus.mar_load, bus.mdr_load_bus, bus.mdr_load_low,
                       bus.mdr_load_high, bus.ram_write}, 16'h0000);
    chk("abort.resp_vld", 16'(bus.resp_valid), 16'h0);
    rw_seen = 1'b0;
    rv_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ram_write)  rw_seen = 1'b1;
      if (bus.resp_valid) rv_seen = 1'b1;
    end
    chk("abort.no_ram_write", 16'(rw_seen), 16'h0);
    chk("abort.no_resp", 16'(rv_seen), 16'h0);
    chk("abort.ram30", 16'(ram_m[8'h30]), 16'h0055);
    chk("abort.ram31", 16'(ram_m[8'h31]), 16'h0066);

    run_txn(1'b0, 16'hFFFF, 16'h0000, 16'h5678, 16'h0000, "rdFFFF");

`ifdef MEMSEQ_BYTE_READ_EN
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b1;
    bus.req_addr  = 16'h0011;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_byte  = 1'b0;
    chk("byte.p0_mar", 16'(bus.mar_load), 16'h1);
    chk("byte.p0_high", 16'(bus.mdr_load_high), 16'h0);
    @(negedge clk);
    chk("byte.p1_low", 16'(bus.mdr_load_low), 16'h1);
    chk("byte.p1_nomar", 16'(bus.mar_load), 16'h0);
    chk("byte.p1_high", 16'(bus.mdr_load_high), 16'h0);
    @(negedge clk);
    chk("byte.resp_vld", 16'(bus.resp_valid), 16'h1);
    chk("byte.resp_data", bus.resp_data, 16'h0012);
    chk("byte.p2_high", 16'(bus.mdr_load_high), 16'h0);
    @(negedge clk);
    chk("byte.after_rdy", 16'(bus.req_ready), 16'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
